// File: rtl/rce_pkg.sv
// rce_pkg -- shared definitions for the RCE (rotate-XOR circulant) QC-LDPC
// encoder/checker family.
//   rce_state_e : checker FSM states (IDLE=0, MSG=1, PAR=2, DONE=3)
//   BEAT_CNT_W  : width of the message-beat counter
//   RCE_MAX_W   : widest circulant the rotl helper can handle
//   rotl        : left rotate of the low w bits of a vector (shared with the
//                 encoder's parity unit)
package rce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_PAR  = 2'd2,
    ST_DONE = 2'd3
  } rce_state_e;

  localparam int BEAT_CNT_W = 8;
  localparam int RCE_MAX_W  = 1024;

  // Rotate the low w bits of v left by (sh mod w); bits above w return as 0.
  function automatic logic [RCE_MAX_W-1:0] rotl(input logic [RCE_MAX_W-1:0] v,
                                                input int w,
                                                input int sh);
    logic [RCE_MAX_W-1:0] mask;
    logic [RCE_MAX_W-1:0] vm;
    int                   s;
    mask = ~({RCE_MAX_W{1'b1}} << w);
    vm   = v & mask;
    s    = sh % w;
    // For s == 0 the right shift by w yields zero because vm < 2**w.
    return ((vm << s) | (vm >> (w - s))) & mask;
  endfunction

endpackage

// File: rtl/rce_rotxor_array.sv
// rce_rotxor_array -- purely combinational beat contribution of one message
// beat: c = XOR over j of (in_data[j] ? rotl(f, j mod M) : 0).
// Ports:
//   in_data [Lm-1:0] : message beat
//   f       [M-1:0]  : circulant generator row for this beat
//   c       [M-1:0]  : contribution to the parity accumulator
module rce_rotxor_array
  import rce_pkg::*;
#(
  parameter int Lm = 32,
  parameter int M  = 32
) (
  input  logic [Lm-1:0] in_data,
  input  logic [M-1:0]  f,
  output logic [M-1:0]  c
);

  logic [RCE_MAX_W-1:0] f_ext_s;
  logic [M-1:0]         c_s;

  assign f_ext_s = RCE_MAX_W'(f);

  // XOR together the rotated copies of f selected by each set message bit.
  always_comb begin
    c_s = '0;
    for (int j = 0; j < Lm; j++) begin
      if (in_data[j]) begin
        c_s = c_s ^ M'(rotl(f_ext_s, M, j));
      end else begin
        c_s = c_s;
      end
    end
  end

  assign c = c_s;

endmodule

// File: rtl/rce_syndrome_checker.sv
// rce_syndrome_checker -- receive-side syndrome check for the RCE encoder.
// Re-encodes NUM_BLK message beats, XORs with the received parity beat and
// presents the M-bit syndrome plus an error flag until accepted.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_data/par_in/f : beat input (parity from par_in)
//   msg_out/msg_valid                  : registered echo of message beats
//   out_valid/out_ready/syndrome/err   : held result handshake
//   err_cnt                            : errored-codeword count
// Build option: define RCE_ERR_COUNT_EN to enable the saturating err_cnt;
// otherwise err_cnt is tied to zero.
module rce_syndrome_checker
  import rce_pkg::*;
#(
  parameter int Lm      = 32,
  parameter int M       = 32,
  parameter int NUM_BLK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [Lm-1:0] in_data,
  input  logic [M-1:0]  par_in,
  input  logic [M-1:0]  f,
  output logic [Lm-1:0] msg_out,
  output logic          msg_valid,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  syndrome,
  output logic          err,
  output logic [15:0]   err_cnt
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NUM_BLK);

  rce_state_e            state_q, state_d;
  logic [M-1:0]          acc_q, acc_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [Lm-1:0]         msg_out_q, msg_out_d;
  logic                  msg_valid_q, msg_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic [M-1:0]          syndrome_q, syndrome_d;
  logic                  err_q, err_d;

  logic [M-1:0]          c_s;
  logic [M-1:0]          par_chk_s;
  logic                  in_ready_s;
  logic                  in_fire_s;
  logic                  res_fire_s;

  rce_rotxor_array #(
    .Lm (Lm),
    .M  (M)
  ) u_rotxor (
    .in_data (in_data),
    .f       (f),
    .c       (c_s)
  );

  // Only DONE refuses beats, so nothing is dropped while a result is pending.
  assign in_ready_s = (state_q != ST_DONE);
  assign in_fire_s  = in_valid && in_ready_s;
  assign res_fire_s = out_valid_q && out_ready;
  assign par_chk_s  = acc_q ^ par_in;

  // Next-state, accumulator and result register update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    msg_out_d   = msg_out_q;
    msg_valid_d = 1'b0;
    out_valid_d = out_valid_q;
    syndrome_d  = syndrome_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire_s) begin
          acc_d       = c_s;
          beat_cnt_d  = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
          msg_out_d   = in_data;
          msg_valid_d = 1'b1;
          state_d     = (LAST_BEAT == 8'd1) ? ST_PAR : ST_MSG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MSG: begin
        if (in_fire_s) begin
          acc_d       = acc_q ^ c_s;
          beat_cnt_d  = beat_cnt_q + 8'd1;
          msg_out_d   = in_data;
          msg_valid_d = 1'b1;
          state_d     = (beat_cnt_d == LAST_BEAT) ? ST_PAR : ST_MSG;
        end else begin
          state_d = ST_MSG;
        end
      end
      ST_PAR: begin
        if (in_fire_s) begin
          syndrome_d  = par_chk_s;
          err_d       = |par_chk_s;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_PAR;
        end
      end
      ST_DONE: begin
        if (res_fire_s) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          beat_cnt_d  = '0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      msg_out_q   <= '0;
      msg_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      syndrome_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      msg_out_q   <= msg_out_d;
      msg_valid_q <= msg_valid_d;
      out_valid_q <= out_valid_d;
      syndrome_q  <= syndrome_d;
      err_q       <= err_d;
    end
  end

`ifdef RCE_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count errored results at handshake, saturating at all-ones.
  always_comb begin
    if (res_fire_s && err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Errored-codeword counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

  assign in_ready  = in_ready_s;
  assign msg_out   = msg_out_q;
  assign msg_valid = msg_valid_q;
  assign out_valid = out_valid_q;
  assign syndrome  = syndrome_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rce_syndrome_checker.sv
// tb_rce_syndrome_checker -- self-checking bench for rce_syndrome_checker.
// DUT a: Lm=8, M=8, NUM_BLK=2.  DUT b: Lm=16, M=8, NUM_BLK=1 (wrap rotation).
// Expected syndromes come from an arithmetic model: rotating an 8-bit value
// left by s equals multiplying by 2**s modulo 255 (0xFF maps to itself).
module tb_rce_syndrome_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        a_in_valid, a_in_ready, a_msg_valid, a_out_valid, a_out_ready, a_err;
  logic [7:0]  a_in_data, a_par_in, a_f, a_msg_out, a_syndrome;
  logic [15:0] a_err_cnt;

  logic        b_in_valid, b_in_ready, b_msg_valid, b_out_valid, b_out_ready, b_err;
  logic [15:0] b_in_data, b_msg_out;
  logic [7:0]  b_par_in, b_f, b_syndrome;
  logic [15:0] b_err_cnt;

  rce_syndrome_checker #(.Lm(8), .M(8), .NUM_BLK(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .par_in(a_par_in), .f(a_f), .msg_out(a_msg_out),
    .msg_valid(a_msg_valid), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .syndrome(a_syndrome), .err(a_err), .err_cnt(a_err_cnt)
  );

  rce_syndrome_checker #(.Lm(16), .M(8), .NUM_BLK(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .par_in(b_par_in), .f(b_f), .msg_out(b_msg_out),
    .msg_valid(b_msg_valid), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .syndrome(b_syndrome), .err(b_err), .err_cnt(b_err_cnt)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int a_pulses = 0;

  logic [7:0]  a_acc;
  int          a_cnt_exp;
  int          b_cnt_exp;

  // Counts msg_valid pulses of DUT a outside reset.
  always @(negedge clk) begin
    if (rst && a_msg_valid) a_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rot8(input logic [7:0] v, input int s);
    int x;
    if (v == 8'hFF) return 8'hFF;
    x = (int'(v) << (s % 8)) % 255;
    return 8'(x);
  endfunction

  function automatic logic [7:0] ref_c(input int d, input int nbits, input logic [7:0] fv);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < nbits; j++) begin
      if (((d >> j) & 1) == 1) r = r ^ rot8(fv, j);
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_ready();
    int n;
    n = 0;
    while (a_in_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) chk("a_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic a_msg(input logic [7:0] d, input logic [7:0] fv);
    wait_a_ready();
    a_in_valid = 1'b1; a_in_data = d; a_f = fv; a_par_in = 8'($urandom);
    cyc();
    a_in_valid = 1'b0;
    a_acc = a_acc ^ ref_c(int'(d), 8, fv);
    chk("a_msg_valid", 32'(a_msg_valid), 32'd1);
    chk("a_msg_out", 32'(a_msg_out), 32'(d));
  endtask

  task automatic a_idle(input int n, input logic [7:0] last_msg);
    for (int i = 0; i < n; i++) begin
      a_in_valid = 1'b0; a_in_data = 8'($urandom); a_f = 8'($urandom);
      cyc();
      chk("a_idle_msg_valid", 32'(a_msg_valid), 32'd0);
      chk("a_idle_msg_out", 32'(a_msg_out), 32'(last_msg));
    end
  endtask

  task automatic a_par(input logic [7:0] p);
    wait_a_ready();
    a_in_valid = 1'b1; a_in_data = 8'($urandom); a_f = 8'($urandom); a_par_in = p;
    cyc();
    a_in_valid = 1'b0;
    chk("a_par_out_valid", 32'(a_out_valid), 32'd1);
    chk("a_par_msg_valid", 32'(a_msg_valid), 32'd0);
  endtask

  task automatic a_collect(input logic [7:0] exp_syn);
    logic exp_err;
    exp_err = (exp_syn != 8'h00);
    chk("a_out_valid", 32'(a_out_valid), 32'd1);
    chk("a_syndrome", 32'(a_syndrome), 32'(exp_syn));
    chk("a_err", 32'(a_err), 32'(exp_err));
    a_out_ready = 1'b1;
    cyc();
    a_out_ready = 1'b0;
`ifdef RCE_ERR_COUNT_EN
    if (exp_err) a_cnt_exp++;
`endif
    a_acc = 8'h00;
    chk("a_out_valid_drop", 32'(a_out_valid), 32'd0);
    chk("a_in_ready_idle", 32'(a_in_ready), 32'd1);
    chk("a_err_cnt", 32'(a_err_cnt), 32'(a_cnt_exp));
  endtask

  task automatic b_codeword(input logic [15:0] d, input logic [7:0] fv, input logic [7:0] p);
    logic [7:0] exp_syn;
    exp_syn = ref_c(int'(d), 16, fv) ^ p;
    b_in_valid = 1'b1; b_in_data = d; b_f = fv;
    cyc();
    chk("b_msg_valid", 32'(b_msg_valid), 32'd1);
    chk("b_msg_out", 32'(b_msg_out), 32'(d));
    b_in_data = 16'($urandom); b_par_in = p;
    cyc();
    b_in_valid = 1'b0;
    chk("b_out_valid", 32'(b_out_valid), 32'd1);
    chk("b_syndrome", 32'(b_syndrome), 32'(exp_syn));
    chk("b_err", 32'(b_err), 32'(exp_syn != 8'h00));
    b_out_ready = 1'b1;
    cyc();
    b_out_ready = 1'b0;
`ifdef RCE_ERR_COUNT_EN
    if (exp_syn != 8'h00) b_cnt_exp++;
`endif
    chk("b_out_valid_drop", 32'(b_out_valid), 32'd0);
    chk("b_err_cnt", 32'(b_err_cnt), 32'(b_cnt_exp));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    a_acc = 8'h00; a_cnt_exp = 0; b_cnt_exp = 0;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    cyc();
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_msg_valid", 32'(a_msg_valid), 32'd0);
    chk("rst_msg_out", 32'(a_msg_out), 32'd0);
    chk("rst_syndrome", 32'(a_syndrome), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_err_cnt", 32'(a_err_cnt), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    rst = 1'b1;
    cyc();
  endtask

  initial begin
    int p0;
    logic [7:0] d0, d1, f0, f1, par;
    rst = 1'b0;
    a_in_valid = 1'b0; a_in_data = 8'h00; a_par_in = 8'h00; a_f = 8'h00; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 16'h0000; b_par_in = 8'h00; b_f = 8'h00; b_out_ready = 1'b0;
    a_acc = 8'h00; a_cnt_exp = 0; b_cnt_exp = 0;
    #2;
    do_reset();

    // Clean codeword
    a_msg(8'h01, 8'h03); a_msg(8'h02, 8'h01); a_par(8'h01);
    a_collect(8'h00);

    // Single-bit error
    a_msg(8'h01, 8'h03); a_msg(8'h02, 8'h01); a_par(8'h81);
    a_collect(8'h80);

    // Backpressure: pending result blocks further beats
    a_msg(8'h01, 8'h03); a_msg(8'h02, 8'h01); a_par(8'h81);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'($urandom); a_f = 8'($urandom); a_par_in = 8'($urandom);
      cyc();
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_out_valid", 32'(a_out_valid), 32'd1);
      chk("bp_syndrome", 32'(a_syndrome), 32'h80);
    end
    a_in_valid = 1'b0;
    a_collect(8'h80);

    // Input stalls between beats
    p0 = a_pulses;
    a_msg(8'h01, 8'h03); a_idle(3, 8'h01);
    a_msg(8'h02, 8'h01); a_idle(3, 8'h02);
    a_par(8'h01);
    a_collect(8'h00);
    chk("stall_pulses", 32'(a_pulses - p0), 32'd2);

    // Mid-codeword reset discards the partial accumulator
    a_msg(8'h01, 8'h03);
    do_reset();
    a_msg(8'h01, 8'h03); a_msg(8'h02, 8'h01); a_par(8'h01);
    a_collect(8'h00);

    // Randomized codewords against the model
    for (int k = 0; k < 25; k++) begin
      d0 = 8'($urandom); d1 = 8'($urandom); f0 = 8'($urandom); f1 = 8'($urandom);
      a_msg(d0, f0); a_idle(int'($urandom_range(0, 2)), d0);
      a_msg(d1, f1); a_idle(int'($urandom_range(0, 2)), d1);
      par = ($urandom_range(0, 1) == 0) ? a_acc : 8'($urandom);
      if ($urandom_range(0, 1) == 1) a_out_ready = 1'b1;
      a_par(par);
      a_out_ready = 1'b0;
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
        cyc();
        chk("rnd_hold_valid", 32'(a_out_valid), 32'd1);
      end
      a_collect(a_acc ^ par);
    end

    // Wrap rotation on the wide-message instance
    b_codeword(16'h0100, 8'h01, 8'h01);
    for (int k = 0; k < 8; k++) begin
      b_codeword(16'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
